// File: rtl/imem_loader_if.sv
// Byte-stream load bus between an image source and the instruction-memory loader.
// master = image source / test driver, slave = loader.
interface imem_loader_if;
  logic        start;
  logic [7:0]  length;
  logic        bytevalid;
  logic [7:0]  bytedata;
  logic        byteready;
  logic        wren;
  logic [23:0] wraddr;
  logic [7:0]  wrdata;
  logic        cpuhold;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, length, bytevalid, bytedata,
    input  byteready, wren, wraddr, wrdata, cpuhold, busy, done, error
  );

  modport slave (
    input  start, length, bytevalid, bytedata,
    output byteready, wren, wraddr, wrdata, cpuhold, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: takes Length 24-bit instructions as a byte stream
// (MSB first), writes them to consecutive byte addresses, and holds the CPU
// until the image is complete. Stalls longer than TIMEOUT cycles abort to ERR.
module imem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t        state, state_nx;
  logic [9:0]    total_in, total, cnt;
  logic [IW-1:0] idle;
  logic          accept, start_ok, start_seen, last_byte, timeout_hit;

  // Length*3 needs 10 bits (255*3 = 765)
  assign total_in    = 10'(bus.length) * 10'd3;
  assign start_ok    = (bus.length != 8'd0) && (int'(total_in) <= MEM_BYTES);
  assign start_seen  = bus.start && (state == IDLE || state == ERR);
  assign accept      = (state == LOAD) && bus.bytevalid;
  assign last_byte   = (cnt == total - 10'd1);
  assign timeout_hit = !accept && (idle == IW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx      = state;
    bus.byteready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.error     = 1'b0;
    bus.cpuhold   = 1'b1;
    case (state)
      IDLE: begin
        bus.cpuhold = 1'b0;
        if (bus.start) state_nx = start_ok ? LOAD : ERR;
      end
      LOAD: begin
        bus.byteready = 1'b1;
        bus.busy      = 1'b1;
        if (accept && last_byte) state_nx = DONE;
        else if (timeout_hit)    state_nx = ERR;
      end
      // the final byte's write strobe happens here, still under CpuHold
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        bus.error = 1'b1;
        if (bus.start) state_nx = start_ok ? LOAD : ERR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte/idle counters and the registered write port (one cycle after accept)
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idle       <= '0;
      total      <= '0;
      bus.wren   <= 1'b0;
      bus.wraddr <= '0;
      bus.wrdata <= '0;
    end else begin
      bus.wren <= accept;
      if (accept) begin
        bus.wraddr <= 24'(cnt);
        bus.wrdata <= bus.bytedata;
        cnt        <= cnt + 10'd1;
        idle       <= '0;
      end else if (state == LOAD) begin
        idle <= idle + IW'(1);
      end
      if (start_seen && start_ok) begin
        cnt   <= '0;
        idle  <= '0;
        total <= total_in;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: state table for Start legality,
// hand sequences for the multi-cycle corners, randomized loads vs a write-list model.
module tb_imem_loader;
  localparam int MB = 128;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if bus();
  imem_loader #(.MEM_BYTES(MB), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int tests = 0;
  int fails = 0;

  // Observed memory writes
  int wa[$];
  int wd[$];
  int ndone = 0;
  always @(negedge clk) begin
    if (bus.wren === 1'b1) begin
      wa.push_back(int'(bus.wraddr));
      wd.push_back(int'(bus.wrdata));
    end
    if (bus.done === 1'b1) ndone++;
  end

  typedef struct {
    bit rf;   // reset before this row
    int len;
    bit busy; // expected LOAD afterwards
    bit err;  // expected ERR afterwards
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    ndone = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bytevalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_load(input int len);
    bus.start = 1'b1;
    bus.length = 8'(len);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_ready"}, int'(bus.byteready), 0);
    chk({n, "_wren"},  int'(bus.wren), 0);
    chk({n, "_addr"},  int'(bus.wraddr), 0);
    chk({n, "_data"},  int'(bus.wrdata), 0);
    chk({n, "_hold"},  int'(bus.cpuhold), 0);
    chk({n, "_busy"},  int'(bus.busy), 0);
    chk({n, "_done"},  int'(bus.done), 0);
    chk({n, "_err"},   int'(bus.error), 0);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps (< TIMEOUT)
  task automatic feed(input logic [7:0] q[$], input int mode);
    int idx = 0;
    int cyc = 0;
    int gap = 0;
    logic v, r;
    while (idx < q.size() && cyc < 500) begin
      r = bus.byteready;
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 2) == 1);
        default: v = ($urandom_range(0, 2) != 0) || (gap >= 3);
      endcase
      gap = v ? 0 : gap + 1;
      bus.bytevalid = v;
      bus.bytedata = q[idx];
      @(negedge clk);
      cyc++;
      if (v && r) idx++;
    end
    bus.bytevalid = 1'b0;
    if (idx < q.size()) chk("feed_timeout", idx, q.size());
  endtask

  // Expected memory image: byte i of the stream lands at address i
  task automatic check_writes(input string n, input logic [7:0] q[$]);
    chk({n, "_nwrites"}, wa.size(), q.size());
    for (int i = 0; i < wa.size() && i < q.size(); i++) begin
      chk({n, "_addr"}, wa[i], i);
      chk({n, "_data"}, wd[i], int'(q[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] h[$];
    logic [23:0] ins;
    int len;

    bus.start = 1'b0;
    bus.length = 8'd0;
    bus.bytevalid = 1'b0;
    bus.bytedata = 8'd0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    // Start legality table (state carries between rows without reset)
    tbl[0] = '{1'b1, 0,   1'b0, 1'b1};  // zero length
    tbl[1] = '{1'b0, 43,  1'b0, 1'b1};  // 129 > 128, ERR stays ERR
    tbl[2] = '{1'b0, 1,   1'b1, 1'b0};  // legal start from ERR
    tbl[3] = '{1'b0, 0,   1'b1, 1'b0};  // start in LOAD ignored
    tbl[4] = '{1'b1, 42,  1'b1, 1'b0};  // 126 fits
    tbl[5] = '{1'b1, 255, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 85,  1'b0, 1'b1};  // 255 > 128
    tbl[7] = '{1'b0, 2,   1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rf) do_reset();
      start_load(tbl[i].len);
      chk($sformatf("tbl%0d_busy", i),  int'(bus.busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_err", i),   int'(bus.error), int'(tbl[i].err));
      chk($sformatf("tbl%0d_hold", i),  int'(bus.cpuhold), 1);
      chk($sformatf("tbl%0d_ready", i), int'(bus.byteready), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_wren", i),  int'(bus.wren), 0);
    end

    // Basic six-byte load, back-to-back
    do_reset(); clr();
    start_load(2);
    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    feed(q, 0);
    chk("b2b_done", int'(bus.done), 1);
    chk("b2b_lastwren", int'(bus.wren), 1);
    chk("b2b_lastaddr", int'(bus.wraddr), 5);
    chk("b2b_ready", int'(bus.byteready), 0);
    chk("b2b_hold", int'(bus.cpuhold), 1);
    @(negedge clk);
    chk("b2b_done_off", int'(bus.done), 0);
    chk("b2b_hold_off", int'(bus.cpuhold), 0);
    chk("b2b_wren_off", int'(bus.wren), 0);
    check_writes("b2b", q);
    chk("b2b_ndone", ndone, 1);

    // Valid toggling every other cycle
    do_reset(); clr();
    start_load(2);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    feed(q, 1);
    chk("tog_done", int'(bus.done), 1);
    @(negedge clk);
    check_writes("tog", q);

    // Timeout after one byte, then legal restart from ERR
    do_reset(); clr();
    start_load(1);
    q = '{8'h5A};
    feed(q, 0);
    for (int i = 1; i < TO; i++) @(negedge clk);
    chk("to_before_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("to_err", int'(bus.error), 1);
    chk("to_busy", int'(bus.busy), 0);
    chk("to_hold", int'(bus.cpuhold), 1);
    chk("to_ready", int'(bus.byteready), 0);
    check_writes("to", q);
    start_load(1);
    chk("to_restart_busy", int'(bus.busy), 1);

    // Reset after third byte of a three-instruction load
    do_reset(); clr();
    start_load(3);
    q = '{8'hC1, 8'hC2, 8'hC3};
    feed(q, 0);
    rst = 1'b1;
    bus.bytevalid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rstmid");
    repeat (4) @(negedge clk);
    bus.bytevalid = 1'b0;
    @(negedge clk);
    chk("rstmid_nwrites", wa.size(), 3);

    // Valid in IDLE ignored; Start mid-LOAD ignored
    do_reset(); clr();
    bus.bytevalid = 1'b1;
    bus.bytedata = 8'h77;
    repeat (3) @(negedge clk);
    bus.bytevalid = 1'b0;
    chk("idlevalid_nwrites", wa.size(), 0);
    start_load(2);
    q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6};
    h = q[0:1];
    feed(h, 0);
    start_load(1);
    chk("midstart_busy", int'(bus.busy), 1);
    h = q[2:5];
    feed(h, 0);
    chk("midstart_done", int'(bus.done), 1);
    @(negedge clk);
    check_writes("midstart", q);

    // Randomized loads: instruction words split MSB first
    for (int it = 0; it < 20; it++) begin
      do_reset(); clr();
      len = $urandom_range(1, MB / 3);
      q.delete();
      for (int k = 0; k < len; k++) begin
        ins = 24'($urandom());
        q.push_back(ins[23:16]);
        q.push_back(ins[15:8]);
        q.push_back(ins[7:0]);
      end
      start_load(len);
      feed(q, 2);
      chk("rnd_done", int'(bus.done), 1);
      @(negedge clk);
      chk("rnd_hold_off", int'(bus.cpuhold), 0);
      check_writes("rnd", q);
      chk("rnd_ndone", ndone, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
